// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM states, mid-bit sample offsets and parity helpers for the UART receiver.
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} parity_t;
  localparam int MID_M1 = -1;
  localparam int MID = 0;
  localparam int MID_P1 = 1;
  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 2-of-3 mid-bit majority vote.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int prescale_w = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  rx,
  input  logic [prescale_w-1:0] prescale,
  output logic                  sample,
  output logic                  bit_done,
  output logic                  vote
);
  logic [prescale_w-1:0] edge_cnt;
  logic [prescale_w-1:0] half;
  logic [1:0] early;
  assign half = prescale >> 1;
  assign bit_done = edge_cnt == prescale - prescale_w'(1);
  assign sample = edge_cnt == prescale_w'(int'(half) + MID_P1);
  // third sample is the live line so the vote is usable even when P=4 makes it coincide with bit_done
  assign vote = majority(early[0], early[1], rx);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      edge_cnt <= '0;
      early <= '0;
    end else begin
      edge_cnt <= (!run || bit_done) ? '0 : edge_cnt + prescale_w'(1);
      if (edge_cnt == prescale_w'(int'(half) + MID_M1)) early[0] <= rx;
      if (edge_cnt == prescale_w'(int'(half) + MID)) early[1] <= rx;
    end
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: frames start/data/parity/stop from an oversampled serial line into a byte
// with a one-cycle valid strobe; parity and stop errors are flagged and suppress the strobe.
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int width = 8,
  parameter int prescale_w = 6
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  RX_IN,
  input  logic [prescale_w-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [width-1:0]      P_DATA,
  output logic                  Data_Valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error
);
  localparam int cw = $clog2(width);
  state_t state;
  parity_t par_typ;
  logic [prescale_w-1:0] pre;
  logic [width-1:0] shift;
  logic [cw-1:0] bit_cnt;
  logic par_en, par_bad, stop_ok, stop_now, enter;
  logic sample, bit_done, vote;
  uart_rx_sampler #(.prescale_w(prescale_w)) u_sampler (
    .clk(CLK),
    .rst_n(Reset),
    .run(state != IDLE),
    .rx(RX_IN),
    .prescale(pre),
    .sample(sample),
    .bit_done(bit_done),
    .vote(vote)
  );
  assign stop_now = sample ? vote : stop_ok;
  assign enter = !RX_IN && (state == IDLE || (state == STOP && bit_done));
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      pre <= '0;
      par_en <= 1'b0;
      par_typ <= EVEN;
      par_bad <= 1'b0;
      stop_ok <= 1'b0;
      shift <= '0;
      bit_cnt <= '0;
      P_DATA <= '0;
      Data_Valid <= 1'b0;
      Parity_Error <= 1'b0;
      Stop_Error <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      if (enter) begin
        pre <= Prescale;
        par_en <= PAR_EN;
        par_typ <= parity_t'(PAR_TYP);
      end
      case (state)
        IDLE: if (!RX_IN) state <= START;
        START:
          if (sample && vote) state <= IDLE;
          else begin
            if (sample) begin
              Parity_Error <= 1'b0;
              Stop_Error <= 1'b0;
              par_bad <= 1'b0;
              stop_ok <= 1'b1;
            end
            if (bit_done) begin
              state <= DATA;
              bit_cnt <= '0;
            end
          end
        DATA: begin
          if (sample) shift[bit_cnt] <= vote;
          if (bit_done) begin
            bit_cnt <= bit_cnt + cw'(1);
            if (bit_cnt == cw'(width - 1)) state <= par_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (sample) par_bad <= vote != ((^shift) ^ (par_typ == ODD));
          if (bit_done) state <= STOP;
        end
        STOP: begin
          if (sample && !vote) begin
            Stop_Error <= 1'b1;
            stop_ok <= 1'b0;
          end
          if (bit_done) begin
            if (stop_now && !par_bad) begin
              P_DATA <= shift;
              Data_Valid <= 1'b1;
            end
            Parity_Error <= par_bad;
            state <= RX_IN ? IDLE : START;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: scoreboard bench; good frames push expected byte/latency, the
// Data_Valid monitor pops and compares.
module tb_uart_rx_deserializer;
  typedef struct {
    logic [7:0] d;
    int start;
    int lat;
  } exp_t;
  logic CLK = 0, Reset = 0, RX_IN = 1, PAR_EN = 0, PAR_TYP = 0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic Data_Valid, Parity_Error, Stop_Error;
  int total = 0, bad = 0, cyc = 0, dv_cnt = 0, n0;
  logic prev_dv = 0;
  exp_t sb[$];
  exp_t e;
  int dv_times[$];
  uart_rx_deserializer #(.width(8), .prescale_w(6)) dut (
    .CLK(CLK),
    .Reset(Reset),
    .RX_IN(RX_IN),
    .Prescale(Prescale),
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA),
    .Data_Valid(Data_Valid),
    .Parity_Error(Parity_Error),
    .Stop_Error(Stop_Error)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (Data_Valid) begin
      chk("dv_pulse", 32'(prev_dv), 0);
      dv_cnt++;
      dv_times.push_back(cyc);
      if (sb.size() == 0) chk("sb_empty", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("p_data", 32'(P_DATA), 32'(e.d));
        chk("latency", cyc - e.start, e.lat);
      end
    end
    prev_dv = Data_Valid;
  end
  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(posedge CLK);
    #1;
  endtask
  task automatic idle(input int n);
    RX_IN = 1;
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                            input logic par_flip, input logic stop_bit);
    exp_t x;
    Prescale = 6'(p);
    PAR_EN = pe;
    PAR_TYP = pt;
    x.d = d;
    x.start = cyc + 1;
    x.lat = (10 + int'(pe)) * p;
    if (!par_flip && stop_bit) sb.push_back(x);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pe) send_bit((^d) ^ pt ^ par_flip, p);
    send_bit(stop_bit, p);
    RX_IN = 1;
  endtask
  task automatic flags(input string tag, input logic pe_exp, input logic se_exp, input logic [7:0] d_exp);
    chk({tag, "_perr"}, 32'(Parity_Error), 32'(pe_exp));
    chk({tag, "_serr"}, 32'(Stop_Error), 32'(se_exp));
    chk({tag, "_pdata"}, 32'(P_DATA), 32'(d_exp));
  endtask
  initial begin
    #2;
    chk("rst_pdata", 32'(P_DATA), 0);
    chk("rst_dv", 32'(Data_Valid), 0);
    chk("rst_perr", 32'(Parity_Error), 0);
    chk("rst_serr", 32'(Stop_Error), 0);
    @(posedge CLK);
    #1 Reset = 1;
    idle(5);
    send_frame(8'hA5, 8, 0, 0, 0, 1);
    idle(4);
    flags("a5", 0, 0, 8'hA5);
    chk("a5_cnt", dv_cnt, 1);
    send_frame(8'h3C, 16, 1, 0, 0, 1);
    idle(4);
    flags("3c", 0, 0, 8'h3C);
    send_frame(8'h3C, 16, 1, 0, 1, 1);
    idle(4);
    flags("3c_par", 1, 0, 8'h3C);
    chk("3c_cnt", dv_cnt, 2);
    send_frame(8'h01, 32, 1, 1, 0, 0);
    idle(4);
    flags("01_stop", 0, 1, 8'h3C);
    chk("01_cnt", dv_cnt, 2);
    send_frame(8'h55, 32, 1, 1, 0, 1);
    idle(4);
    flags("55", 0, 0, 8'h55);
    Prescale = 6'd8;
    PAR_EN = 0;
    send_bit(1'b0, 2);
    idle(30);
    flags("glitch", 0, 0, 8'h55);
    chk("glitch_cnt", dv_cnt, 3);
    n0 = dv_times.size();
    send_frame(8'h11, 16, 0, 0, 0, 1);
    send_frame(8'h22, 16, 0, 0, 0, 1);
    send_frame(8'h33, 16, 0, 0, 0, 1);
    idle(4);
    chk("b2b_cnt", dv_times.size() - n0, 3);
    if (dv_times.size() >= n0 + 3) begin
      chk("b2b_gap1", dv_times[n0 + 1] - dv_times[n0], 160);
      chk("b2b_gap2", dv_times[n0 + 2] - dv_times[n0 + 1], 160);
    end
    flags("33", 0, 0, 8'h33);
    Prescale = 6'd8;
    send_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 8);
    Reset = 0;
    RX_IN = 1;
    #3;
    chk("mid_rst_pdata", 32'(P_DATA), 0);
    chk("mid_rst_dv", 32'(Data_Valid), 0);
    chk("mid_rst_perr", 32'(Parity_Error), 0);
    chk("mid_rst_serr", 32'(Stop_Error), 0);
    repeat (3) @(posedge CLK);
    #1 Reset = 1;
    idle(100);
    chk("abort_cnt", dv_cnt, 6);
    send_frame(8'h7E, 8, 0, 0, 0, 1);
    idle(4);
    flags("7e", 0, 0, 8'h7E);
    chk("final_cnt", dv_cnt, 7);
    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
